// File: rtl/var_shift_seq_if.sv
// Handshake/data bundle for var_shift_seq: the controller drives the request,
// the shifter returns the working register and the busy/done status.
interface var_shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
);
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, amt, din,
    input  dout, busy, done
  );

  modport slave (
    input  start, dir, amt, din,
    output dout, busy, done
  );
endinterface

// File: rtl/var_shift_seq.sv
// Sequential variable shifter: one bit position per clock under a down-counter.
// Define VAR_SHIFT_ROTATE_EN to rotate instead of zero-filling the vacated bit.
module var_shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input logic           clk,
  input logic           rst,
  var_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dir_r, dir_n;
  logic             busy_r, done_r;
  logic             fill;

  always_comb begin
    state_n = state;
    q_n     = q;
    cnt_n   = cnt;
    dir_n   = dir_r;
    fill    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          dir_n   = bus.dir;
          q_n     = bus.din;
          cnt_n   = bus.amt;
          state_n = (bus.amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef VAR_SHIFT_ROTATE_EN
        fill = dir_r ? q[0] : q[WIDTH-1];
`else
        fill = 1'b0;
`endif
        q_n = dir_r ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
        // Counter only moves while nonzero so it can never wrap.
        if (cnt != '0) cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      cnt    <= cnt_n;
      dir_r  <= dir_n;
      busy_r <= (state_n != IDLE);
      done_r <= (state_n == DONE);
    end
  end

  assign bus.dout = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_var_shift_seq.sv
// Scoreboard bench for var_shift_seq: stimulus pushes expected results, a
// negedge monitor pops and checks them whenever done is presented.
module tb_var_shift_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  typedef struct {
    logic [WIDTH-1:0] dout;
    int               cyc;
    int               amt;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  var_shift_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  var_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare result, latency and busy length at every done pulse;
  // one cycle later confirm done dropped and dout is holding.
  int               busy_run = 0;
  logic             hold_chk = 1'b0;
  logic [WIDTH-1:0] hold_val;
  always @(negedge clk) begin
    if (hold_chk) begin
      hold_chk = 1'b0;
      check("hold_dout", int'(bus.dout), int'(hold_val));
      check("hold_done", int'(bus.done), 0);
      check("hold_busy", int'(bus.busy), 0);
    end
    if (bus.busy) busy_run++;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_dout"}, int'(bus.dout), int'(e.dout));
        check({e.name, "_latency"}, cyc, e.cyc);
        check({e.name, "_busy_len"}, busy_run, e.amt + 1);
        hold_chk = 1'b1;
        hold_val = e.dout;
      end
    end
    if (!bus.busy) busy_run = 0;
  end

  // Called just after a negedge: drive a one-cycle start and record expectations.
  task automatic issue(input string name, input logic [WIDTH-1:0] din,
                       input logic dir, input int amt,
                       input logic [WIDTH-1:0] exp, input logic push);
    exp_t e;
    bus.start = 1'b1;
    bus.din   = din;
    bus.dir   = dir;
    bus.amt   = CNT_W'(amt);
    if (push) begin
      e.dout = exp;
      e.cyc  = cyc + 1 + amt;
      e.amt  = amt;
      e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = ~din;
    bus.dir   = ~dir;
    bus.amt   = '1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || hold_chk) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check({name, "_timeout"}, 1, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({name, "_done_timeout"}, 1, 0);
  endtask

  logic [WIDTH-1:0] e4, e5, e7, e8;

  initial begin
`ifdef VAR_SHIFT_ROTATE_EN
    e4 = 8'hFF; e5 = 8'hC0; e7 = 8'h5A; e8 = 8'hC0;
`else
    e4 = 8'h80; e5 = 8'h40; e7 = 8'h0A; e8 = 8'h80;
`endif
    bus.start = 1'b0;
    bus.din   = '0;
    bus.dir   = 1'b0;
    bus.amt   = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", int'(bus.dout), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset held two cycles in the middle of an amt=5 shift.
    issue("rst_mid", 8'h5A, 1'b0, 5, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_dout", int'(bus.dout), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_done", int'(bus.done), 0);
    repeat (8) @(negedge clk);
    check("rst_mid_idle_busy", int'(bus.busy), 0);

    issue("left3", 8'h01, 1'b0, 3, 8'h08, 1'b1);
    wait_idle("left3");

    issue("amt0", 8'h80, 1'b1, 0, 8'h80, 1'b1);
    wait_idle("amt0");

    // Start re-pulsed while busy must be ignored.
    issue("left7", 8'hFF, 1'b0, 7, e4, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 8'h11;
    bus.dir   = 1'b1;
    bus.amt   = CNT_W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("left7");

    issue("right1", 8'h81, 1'b1, 1, e5, 1'b1);
    wait_idle("right1");

    issue("left2", 8'h3C, 1'b0, 2, 8'hF0, 1'b1);
    wait_idle("left2");

    issue("right4", 8'hA5, 1'b1, 4, e7, 1'b1);
    wait_idle("right4");

    issue("left7b", 8'h81, 1'b0, 7, e8, 1'b1);
    wait_idle("left7b");

    // Back-to-back: second start in the cycle right after done.
    issue("b2b_a", 8'h03, 1'b0, 1, 8'h06, 1'b1);
    wait_done("b2b_a");
    @(negedge clk);
    issue("b2b_b", 8'h40, 1'b1, 2, 8'h10, 1'b1);
    wait_idle("b2b_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
